pri_arbiter: RTL and testbench
==============================

PRI_ARBITER -- requirements
Module: pri_arbiter

Interface
REQ-001 SHALL have parameter WID, default 8, meaning number of requesters (WID >= 2).
REQ-002 SHALL have parameter IDXW, default $clog2(WID), meaning width of the grant index outputs.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all registers on rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port req_i, input, WID bits: request vector, bit n = requester n.
REQ-006 SHALL have port gnt_o, output, WID bits: combinational one-hot grant.
REQ-007 SHALL have port gnt_vld_o, output, 1 bit: combinational, high when any req_i bit is set.
REQ-008 SHALL have port gnt_idx_o, output, IDXW bits: combinational binary index of the granted requester.
REQ-009 SHALL have port gnt_q_o, output, WID bits: registered copy of gnt_o.
REQ-010 SHALL have port gnt_vld_q_o, output, 1 bit: registered copy of gnt_vld_o.
REQ-011 SHALL have port gnt_idx_q_o, output, IDXW bits: registered copy of gnt_idx_o.

Function
REQ-012 SHALL implement fixed priority: bit 0 highest, bit WID-1 lowest.
REQ-013 gnt_o SHALL have exactly the lowest-indexed set bit of req_i set, all other bits 0.
REQ-014 gnt_o SHALL be all-zero when req_i is all-zero.
REQ-015 gnt_o, gnt_vld_o and gnt_idx_o SHALL depend only on the current req_i, with zero-cycle latency; no clock edge is required for them to settle.
REQ-016 gnt_idx_o SHALL be 0 when req_i is all-zero; qualify it with gnt_vld_o.
REQ-017 No combinational output SHALL contain X for any fully defined req_i.
REQ-018 Registered outputs SHALL equal the combinational outputs sampled at the previous rising edge of clk_i, giving one-cycle latency.
REQ-019 Request bits at or above the WID position SHALL NOT exist; narrower stimulus is zero-extended by the connecting logic.
REQ-020 The block SHALL hold no state other than the three output registers; there is no fairness, rotation or lock.

Reset
REQ-021 While rst_i is high, gnt_q_o, gnt_vld_q_o and gnt_idx_q_o SHALL be 0, asynchronously.
REQ-022 Combinational outputs SHALL keep following req_i during reset.
REQ-023 After rst_i deasserts, the registered outputs SHALL update on the first rising edge of clk_i.
REQ-024 Asserting rst_i mid-operation SHALL clear the registered outputs immediately, without waiting for a clock edge.

Structure
REQ-025 A package pri_arbiter_pkg SHALL hold the default WID constant and a function that returns the lowest set bit as a one-hot value.
REQ-026 A sub-module pri_enc SHALL convert the one-hot grant to the binary index plus a valid bit; pri_arbiter instantiates it once.
REQ-027 The design SHALL be synthesizable for any WID from 2 to 64, with no latches.

Verification (WID=8)
REQ-028 req_i=8'h00 -> gnt_o=8'h00, gnt_vld_o=0, gnt_idx_o=0.
REQ-029 req_i=8'h0F -> gnt_o=8'h01, gnt_idx_o=0; req_i=8'h0C -> gnt_o=8'h04, gnt_idx_o=2.
REQ-030 req_i=8'h80 -> gnt_o=8'h80, gnt_idx_o=7; req_i=8'hFF -> gnt_o=8'h01.
REQ-031 Apply 16 random req_i values in 0..15, each held for 5 time units -> gnt_o equals req & -req every step, and is one-hot or zero.
REQ-032 req_i=8'h0A applied before a clock edge -> after that edge gnt_q_o=8'h02, gnt_idx_q_o=1, gnt_vld_q_o=1.
REQ-033 Assert rst_i between clock edges while gnt_q_o=8'h02 -> registered outputs go to 0 immediately while gnt_o stays 8'h02.

Source files
------------

// File: rtl/pri_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pri_arbiter_pkg
// Description : Shared constants and lowest-set-bit helper for pri_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pri_arbiter_pkg;

  localparam int c_default_wid = 8;
  localparam int c_max_wid     = 64;

  // Two's-complement trick: vec & -vec isolates the lowest set bit.
  function automatic logic [c_max_wid-1:0] lowest_set_onehot(
    input logic [c_max_wid-1:0] vec
  );
    return vec & (~vec + {{(c_max_wid-1){1'b0}}, 1'b1});
  endfunction

endpackage : pri_arbiter_pkg
`default_nettype wire

// File: rtl/pri_enc.sv
`default_nettype none
// ============================================================================
// Module      : pri_enc
// Description : One-hot to binary index encoder with valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pri_enc #(
  parameter int WID  = 8,
  parameter int IDXW = $clog2(WID)
) (
  input  logic [WID-1:0]  i_onehot,
  output logic [IDXW-1:0] o_idx,
  output logic            o_vld
);

  // OR-reduction encoding: each index bit collects the one-hot lines whose
  // position has that bit set; an all-zero input yields index 0.
  always_comb begin
    o_idx = '0;
    for (int n = 0; n < WID; n++) begin
      if (i_onehot[n]) begin
        o_idx = o_idx | IDXW'(n);
      end
    end
  end

  assign o_vld = |i_onehot;

endmodule : pri_enc
`default_nettype wire

// File: rtl/pri_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pri_arbiter
// Description : Fixed-priority arbiter (bit 0 highest) with registered copies.
// Revision    : 1.0 - initial release
// ============================================================================
module pri_arbiter
  import pri_arbiter_pkg::*;
#(
  parameter int WID  = c_default_wid,
  parameter int IDXW = $clog2(WID)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [WID-1:0]  req_i,
  output logic [WID-1:0]  gnt_o,
  output logic            gnt_vld_o,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic [WID-1:0]  gnt_q_o,
  output logic            gnt_vld_q_o,
  output logic [IDXW-1:0] gnt_idx_q_o
);

  logic [c_max_wid-1:0] w_req_ext;
  logic [c_max_wid-1:0] w_gnt_ext;
  logic [WID-1:0]       w_gnt;
  logic                 w_vld;
  logic [IDXW-1:0]      w_idx;

  logic [WID-1:0]       r_gnt;
  logic                 r_vld;
  logic [IDXW-1:0]      r_idx;

  assign w_req_ext = c_max_wid'(req_i);
  assign w_gnt_ext = lowest_set_onehot(w_req_ext);
  assign w_gnt     = w_gnt_ext[WID-1:0];

  // Upper grant bits are always zero because the request is zero-extended.
  if (WID < c_max_wid) begin : g_hi_bits
    logic w_unused_hi;
    assign w_unused_hi = |w_gnt_ext[c_max_wid-1:WID];
  end : g_hi_bits

  pri_enc #(
    .WID  (WID),
    .IDXW (IDXW)
  ) u_pri_enc (
    .i_onehot (w_gnt),
    .o_idx    (w_idx),
    .o_vld    (w_vld)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gnt <= '0;
      r_vld <= 1'b0;
      r_idx <= '0;
    end else begin
      r_gnt <= w_gnt;
      r_vld <= w_vld;
      r_idx <= w_idx;
    end
  end

  assign gnt_o       = w_gnt;
  assign gnt_vld_o   = w_vld;
  assign gnt_idx_o   = w_idx;
  assign gnt_q_o     = r_gnt;
  assign gnt_vld_q_o = r_vld;
  assign gnt_idx_q_o = r_idx;

endmodule : pri_arbiter
`default_nettype wire

// File: tb/tb_pri_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pri_arbiter
// Description : Self-checking bench for pri_arbiter (WID=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pri_arbiter;

  localparam int WID  = 8;
  localparam int IDXW = 3;

  logic            clk;
  logic            rst;
  logic [WID-1:0]  req;
  logic [WID-1:0]  gnt;
  logic            gnt_vld;
  logic [IDXW-1:0] gnt_idx;
  logic [WID-1:0]  gnt_q;
  logic            gnt_vld_q;
  logic [IDXW-1:0] gnt_idx_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WID-1:0]  req;
    logic [WID-1:0]  gnt;
    logic            vld;
    logic [IDXW-1:0] idx;
  } vec_t;

  vec_t vecs [11];

  pri_arbiter #(
    .WID  (WID),
    .IDXW (IDXW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .gnt_o       (gnt),
    .gnt_vld_o   (gnt_vld),
    .gnt_idx_o   (gnt_idx),
    .gnt_q_o     (gnt_q),
    .gnt_vld_q_o (gnt_vld_q),
    .gnt_idx_q_o (gnt_idx_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WID-1:0] r;
    logic [WID-1:0] e;

    vecs[0]  = '{8'h00, 8'h00, 1'b0, 3'd0};
    vecs[1]  = '{8'h0F, 8'h01, 1'b1, 3'd0};
    vecs[2]  = '{8'h0C, 8'h04, 1'b1, 3'd2};
    vecs[3]  = '{8'h80, 8'h80, 1'b1, 3'd7};
    vecs[4]  = '{8'hFF, 8'h01, 1'b1, 3'd0};
    vecs[5]  = '{8'h0A, 8'h02, 1'b1, 3'd1};
    vecs[6]  = '{8'h60, 8'h20, 1'b1, 3'd5};
    vecs[7]  = '{8'h50, 8'h10, 1'b1, 3'd4};
    vecs[8]  = '{8'h48, 8'h08, 1'b1, 3'd3};
    vecs[9]  = '{8'hC0, 8'h40, 1'b1, 3'd6};
    vecs[10] = '{8'h00, 8'h00, 1'b0, 3'd0};

    // Reset state, combinational path live during reset
    rst = 1'b1;
    req = 8'h00;
    #2;
    chk("rst_gnt_q", 64'(gnt_q), 64'h0);
    chk("rst_vld_q", 64'(gnt_vld_q), 64'h0);
    chk("rst_idx_q", 64'(gnt_idx_q), 64'h0);
    req = 8'h0C;
    #1;
    chk("rst_comb_gnt", 64'(gnt), 64'h04);
    chk("rst_comb_idx", 64'(gnt_idx), 64'd2);
    @(posedge clk); #1;
    chk("rst_hold_gnt_q", 64'(gnt_q), 64'h0);

    // Deassert, first edge updates registers
    @(negedge clk);
    rst = 1'b0;
    req = 8'h0A;
    @(posedge clk); #1;
    chk("reg_0a_gnt_q", 64'(gnt_q), 64'h02);
    chk("reg_0a_idx_q", 64'(gnt_idx_q), 64'd1);
    chk("reg_0a_vld_q", 64'(gnt_vld_q), 64'd1);

    // Registered outputs hold until the next edge
    req = 8'h80;
    #1;
    chk("comb_80_gnt", 64'(gnt), 64'h80);
    chk("hold_gnt_q", 64'(gnt_q), 64'h02);
    req = 8'h0A;
    @(posedge clk); #2;

    // Mid-cycle reset clears registers immediately
    rst = 1'b1;
    #1;
    chk("async_rst_gnt_q", 64'(gnt_q), 64'h0);
    chk("async_rst_vld_q", 64'(gnt_vld_q), 64'h0);
    chk("async_rst_idx_q", 64'(gnt_idx_q), 64'h0);
    chk("async_rst_comb", 64'(gnt), 64'h02);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_gnt_q", 64'(gnt_q), 64'h02);

    // Table-driven vectors: combinational then registered
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      req = vecs[i].req;
      #1;
      chk($sformatf("v%0d_gnt", i), 64'(gnt), 64'(vecs[i].gnt));
      chk($sformatf("v%0d_vld", i), 64'(gnt_vld), 64'(vecs[i].vld));
      chk($sformatf("v%0d_idx", i), 64'(gnt_idx), 64'(vecs[i].idx));
      @(posedge clk); #1;
      chk($sformatf("v%0d_gnt_q", i), 64'(gnt_q), 64'(vecs[i].gnt));
      chk($sformatf("v%0d_vld_q", i), 64'(gnt_vld_q), 64'(vecs[i].vld));
      chk($sformatf("v%0d_idx_q", i), 64'(gnt_idx_q), 64'(vecs[i].idx));
    end

    // Random low-nibble requests, 5 time units each
    for (int i = 0; i < 16; i++) begin
      r = WID'($urandom_range(0, 15));
      req = r;
      e = r & (~r + 8'd1);
      #1;
      chk($sformatf("rnd%0d_gnt_req%0h", i, r), 64'(gnt), 64'(e));
      chk($sformatf("rnd%0d_onehot0", i), 64'($onehot0(gnt)), 64'd1);
      chk($sformatf("rnd%0d_vld", i), 64'(gnt_vld), 64'(r != 8'h00));
      #4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pri_arbiter
`default_nettype wire
